pwm_gen_multi: RTL and testbench
================================

# pwm_gen_multi

Parametrised multi-channel PWM generator; next generation of the single-channel `pwm_gen`. Generalises it in three ways:
- channel count, duty resolution and clock prescaler are parameters;
- an optional center-aligned mode is added;
- duty-cycle loads are glitch-free via per-channel shadow registers updated at period start.

All channels share one timebase. Per-channel source select (register vs. pin) is global and polarity is per channel. It sits between the register file / input pins and the PWM output pads.

## Interface
- `NCH`, 4, number of PWM channels (≥1)
- `DC_W`, 7, duty/counter width; `MAX = 2**DC_W - 1`
- `PRESC_W`, 4, prescaler value width

- `clk`  in  1  system clock (12 MHz nominal); one clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  timebase enable
- `presc`  in  PRESC_W  one tick every `presc+1` clocks
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period start
- `sel_inpins`  in  1  1 = duty from `pin_dc`, 0 = from `reg_dc` (all channels)
- `invert_polarity`  in  NCH  per-channel output inversion, combinational
- `reg_dc`  in  NCH*DC_W  register duty, channel i at `[i*DC_W +: DC_W]`
- `pin_dc`  in  NCH*DC_W  pin duty, same packing
- `pwm_sig`  out  NCH  PWM outputs
- `period_start`  out  1  one-clock pulse on the tick that begins a period

## Operation
- **Prescaler:**
  - `pcnt` counts clocks; a tick is issued and `pcnt` cleared when `pcnt >= presc`.
  - `>=` makes a mid-count decrease of `presc` take effect at once.
- **Edge mode:** counter `cnt` increments per tick, 0…MAX, then wraps to 0. Period = 2**DC_W ticks.
- **Center mode:**
  - `cnt` runs 0…MAX up, repeats MAX once while `dir` flips, runs MAX…0 down, repeats 0 once while `dir` flips.
  - Period = 2·2**DC_W ticks.
- **Period start:** the tick where `cnt==0` and (edge mode, or center mode with `dir`=up). On that tick:
  - each channel's shadow is loaded from the selected duty;
  - the mode latch is loaded from `center_mode`;
  - `period_start` pulses.
- **Compare:**
  - `duty_eff = (period start) ? selected duty : shadow`.
  - Raw output is active iff `duty_eff == MAX` (forced 100 %) or `cnt < duty_eff`.
  - `duty_eff == 0` gives constant inactive.
- **Output:** raw bit registered per channel; `pwm_sig[i] = raw_q[i] ^ invert_polarity[i]`.
- **Disable (`en`=0):**
  - `pcnt`, `cnt` and `dir` are forced to 0 / 0 / up, and `raw_q` is cleared;
  - shadows hold their values; `period_start` stays 0.
  - The first tick after `en` rises is a period start.
- **Reset values:** `pcnt`=0, `cnt`=0, `dir`=up, mode latch=edge, shadows=0, `raw_q`=0, `period_start`=0, hence `pwm_sig = invert_polarity`.
- **Edge cases:**
  - A change to `reg_dc`/`pin_dc`/`sel_inpins`/`center_mode` mid-period has no effect until the next period start.
  - A change to `invert_polarity` is visible in the same cycle.

## Timing
- Compare-to-output latency is 1 clock: a tick at clock edge k drives `pwm_sig` from edge k.
- `period_start` is registered and asserted during the clock following the period-start tick edge, aligned with the first active output clock.
- With `presc`=0, edge mode, duty D: `pwm_sig` is active for D clocks per 2**DC_W-clock period.
- With `presc`=0, center mode, duty D: active for 2·D clocks, symmetric about the period midpoint.
- Async reset mid-period: all outputs take reset values immediately; the first tick after deassertion (with `en`=1) starts a new period.

## Structure
- Package `pwm_pkg`:
  - default `DC_W`, `PRESC_W`;
  - a mode enum `{PWM_EDGE, PWM_CENTER}`;
  - a direction enum.
- Top `pwm_gen_multi` holds the shared timebase: prescaler, `cnt`, `dir`, mode latch, `period_start`.
- Sub-module `pwm_chan` (shadow register, duty mux, compare, `raw_q`, XOR) is instantiated `NCH` times by a generate loop.

## Test plan
1. Edge mode, `presc`=0, `reg_dc[0]`=32, `en`=1 → `pwm_sig[0]` high 32 clocks, low 96; `period_start` every 128 clocks.
2. Duty 0 / duty 127 on channels 1/2 → `pwm_sig[1]` constantly 0, `pwm_sig[2]` constantly 1, over ≥3 periods.
3. `reg_dc[0]` changes from 32 to 96 at `cnt`=50 → current period still 32 high; next period 96 high; no runt pulse.
4. Center mode, duty 32, `presc`=0 → period 256 clocks, 64 clocks high, high window centred on `cnt`=0 of the period boundary; `presc`=3 → period 1024 clocks.
5. `sel_inpins` switches to `pin_dc`=10, `invert_polarity`=4'b0001 mid-period:
   - `pwm_sig[0]` inverts the same cycle;
   - the 10-tick duty applies from the next period start.
6. `rst_n` pulsed low at `cnt`=60 with `invert_polarity`=4'b1010 → `pwm_sig`=4'b1010 immediately, `cnt`=0; a clean period restarts after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and enums for the multi-channel PWM generator.
package pwm_pkg;
    localparam int DC_W_DEF    = 7;
    localparam int PRESC_W_DEF = 4;

    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel - shadow duty register, duty source mux, compare, output register, polarity.
//   clk, rst_n     : clock, async active-low reset
//   en             : timebase enable (clears the output register when low)
//   tick           : timebase advance strobe
//   pstart         : current tick begins a new period
//   sel_inpins     : 1 = duty from pin_dc, 0 = from reg_dc
//   cnt            : shared timebase counter
//   reg_dc, pin_dc : candidate duty values
//   invert         : output polarity inversion (combinational)
//   pwm_sig        : channel output
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int DC_W = DC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            tick,
    input  logic            pstart,
    input  logic            sel_inpins,
    input  logic [DC_W-1:0] cnt,
    input  logic [DC_W-1:0] reg_dc,
    input  logic [DC_W-1:0] pin_dc,
    input  logic            invert,
    output logic            pwm_sig
);
    localparam logic [DC_W-1:0] MAX = '1;

    logic [DC_W-1:0] shadow;
    logic [DC_W-1:0] duty_sel;
    logic [DC_W-1:0] duty_eff;
    logic            raw_q;

    assign duty_sel = sel_inpins ? pin_dc : reg_dc;
    // On the period-start tick the shadow is being loaded, so compare against the new value directly.
    assign duty_eff = pstart ? duty_sel : shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            raw_q  <= 1'b0;
        end else begin
            if (pstart)
                shadow <= duty_sel;
            if (!en)
                raw_q <= 1'b0;
            else if (tick)
                raw_q <= (duty_eff == MAX) || (cnt < duty_eff);
        end
    end

    assign pwm_sig = raw_q ^ invert;
endmodule

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: multi-channel PWM generator with a shared prescaled timebase and edge/center-aligned modes.
//   clk, rst_n      : clock, async active-low reset
//   en              : timebase enable
//   presc           : one tick every presc+1 clocks
//   center_mode     : 0 = edge-aligned, 1 = center-aligned (taken at period start)
//   sel_inpins      : duty source for all channels, 1 = pin_dc, 0 = reg_dc
//   invert_polarity : per-channel output inversion
//   reg_dc, pin_dc  : packed per-channel duty, channel i at [i*DC_W +: DC_W]
//   pwm_sig         : PWM outputs
//   period_start    : one-clock pulse aligned with the first output clock of a period
module pwm_gen_multi
    import pwm_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DC_W    = DC_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PRESC_W-1:0]  presc,
    input  logic                center_mode,
    input  logic                sel_inpins,
    input  logic [NCH-1:0]      invert_polarity,
    input  logic [NCH*DC_W-1:0] reg_dc,
    input  logic [NCH*DC_W-1:0] pin_dc,
    output logic [NCH-1:0]      pwm_sig,
    output logic                period_start
);
    localparam logic [DC_W-1:0] MAX = '1;

    logic [PRESC_W-1:0] pcnt;
    logic [DC_W-1:0]    cnt;
    pwm_dir_e           dir;
    pwm_mode_e          mode_q;
    logic               tick;
    logic               pstart;
    pwm_mode_e          mode_eff;

    // >= so that lowering presc mid-count ticks immediately instead of waiting for a wrap.
    assign tick     = en && (pcnt >= presc);
    // dir stays up in edge mode, so this covers both modes; in center mode it skips the
    // repeated zero at the bottom turnaround.
    assign pstart   = tick && (cnt == '0) && (dir == DIR_UP);
    assign mode_eff = pstart ? pwm_mode_e'(center_mode) : mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt         <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_q       <= PWM_EDGE;
            period_start <= 1'b0;
        end else if (!en) begin
            pcnt         <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            period_start <= 1'b0;
        end else begin
            period_start <= pstart;
            pcnt         <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                if (pstart)
                    mode_q <= mode_eff;
                if (mode_eff == PWM_EDGE) begin
                    cnt <= cnt + 1'b1;
                    dir <= DIR_UP;
                end else if (dir == DIR_UP) begin
                    // Hold at the top for one tick while turning around.
                    if (cnt == MAX)
                        dir <= DIR_DOWN;
                    else
                        cnt <= cnt + 1'b1;
                end else begin
                    if (cnt == '0)
                        dir <= DIR_UP;
                    else
                        cnt <= cnt - 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_chan #(.DC_W(DC_W)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .tick       (tick),
            .pstart     (pstart),
            .sel_inpins (sel_inpins),
            .cnt        (cnt),
            .reg_dc     (reg_dc[i*DC_W +: DC_W]),
            .pin_dc     (pin_dc[i*DC_W +: DC_W]),
            .invert     (invert_polarity[i]),
            .pwm_sig    (pwm_sig[i])
        );
    end
endmodule

// File: tb/tb_pwm_gen_multi.sv
// tb_pwm_gen_multi: directed and randomized checks of pwm_gen_multi against a period/phase reference model.
module tb_pwm_gen_multi;
    localparam int NCH = 4;
    localparam int DW  = 7;
    localparam int PW  = 4;
    localparam int N   = 128;
    localparam int MAX = 127;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [PW-1:0]     presc = '0;
    logic              center_mode = 1'b0;
    logic              sel_inpins = 1'b0;
    logic [NCH-1:0]    invert_polarity = '0;
    logic [NCH*DW-1:0] reg_dc = '0;
    logic [NCH*DW-1:0] pin_dc = '0;
    logic [NCH-1:0]    pwm_sig;
    logic              period_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the period, with the counter value derived arithmetically.
    int             m_pcnt = 0;
    int             m_ph = 0;
    bit             m_center = 1'b0;
    int             m_sh[NCH];
    logic [NCH-1:0] m_raw = '0;
    logic           m_ps = 1'b0;

    always #5 clk = ~clk;

    pwm_gen_multi #(.NCH(NCH), .DC_W(DW), .PRESC_W(PW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .presc           (presc),
        .center_mode     (center_mode),
        .sel_inpins      (sel_inpins),
        .invert_polarity (invert_polarity),
        .reg_dc          (reg_dc),
        .pin_dc          (pin_dc),
        .pwm_sig         (pwm_sig),
        .period_start    (period_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_duty(int i);
        return sel_inpins ? int'(pin_dc[i*DW +: DW]) : int'(reg_dc[i*DW +: DW]);
    endfunction

    function automatic int pos(int ph, bit c);
        return (!c || ph < N) ? ph : 2*N - 1 - ph;
    endfunction

    task automatic model_reset();
        m_pcnt = 0; m_ph = 0; m_center = 1'b0; m_raw = '0; m_ps = 1'b0;
        for (int i = 0; i < NCH; i++) m_sh[i] = 0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            m_pcnt = 0; m_ph = 0; m_raw = '0; m_ps = 1'b0;
        end else begin
            m_ps = 1'b0;
            if (m_pcnt >= int'(presc)) begin
                m_pcnt = 0;
                if (m_ph == 0) begin
                    m_ps = 1'b1;
                    m_center = center_mode;
                    for (int i = 0; i < NCH; i++) m_sh[i] = sel_duty(i);
                end
                for (int i = 0; i < NCH; i++)
                    m_raw[i] = (m_sh[i] == MAX) || (pos(m_ph, m_center) < m_sh[i]);
                m_ph = (m_ph + 1) % (m_center ? 2*N : N);
            end else begin
                m_pcnt++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        check("pwm_sig", 32'(pwm_sig), 32'(m_raw ^ invert_polarity));
        check("period_start", 32'(period_start), 32'(m_ps));
    endtask

    // Syncs to a period_start, then counts high clocks of one channel until the next one.
    task automatic meas(input int ch, output int hi, output int len, output int wait_n);
        wait_n = 0;
        while (!period_start && wait_n < 5000) begin
            cyc();
            wait_n++;
        end
        check("sync", 32'(wait_n < 5000), 1);
        hi = 0;
        len = 0;
        do begin
            hi += int'(pwm_sig[ch]);
            len++;
            cyc();
        end while (!period_start && len < 5000);
    endtask

    initial begin
        int hi, len, w, d;
        model_reset();
        invert_polarity = 4'b0110;
        repeat (3) cyc();
        check("rst_pwm", 32'(pwm_sig), 32'h6);
        check("rst_ps", 32'(period_start), 0);

        rst_n = 1'b1;
        invert_polarity = '0;
        reg_dc = {7'd0, 7'd127, 7'd0, 7'd32};
        en = 1'b1;
        meas(0, hi, len, w);
        check("t1_first_wait", w, 1);
        check("t1_hi", hi, 32);
        check("t1_len", len, 128);

        for (int k = 0; k < 3; k++) begin
            meas(1, hi, len, w);
            check("t2_duty0", hi, 0);
            meas(2, hi, len, w);
            check("t2_duty127", hi, 128);
        end

        hi = 0;
        for (int k = 0; k < 128; k++) begin
            if (k == 50) reg_dc[6:0] = 7'd96;
            hi += int'(pwm_sig[0]);
            cyc();
        end
        check("t3_cur_hi", hi, 32);
        check("t3_ps", 32'(period_start), 1);
        meas(0, hi, len, w);
        check("t3_next_hi", hi, 96);
        check("t3_next_len", len, 128);

        reg_dc[6:0] = 7'd32;
        center_mode = 1'b1;
        meas(0, hi, len, w);
        meas(0, hi, len, w);
        check("t4_c_hi", hi, 64);
        check("t4_c_len", len, 256);
        presc = 4'd3;
        meas(0, hi, len, w);
        meas(0, hi, len, w);
        check("t4_p3_hi", hi, 256);
        check("t4_p3_len", len, 1024);
        presc = '0;
        center_mode = 1'b0;
        meas(0, hi, len, w);

        repeat (20) cyc();
        sel_inpins = 1'b1;
        pin_dc = '0;
        pin_dc[6:0] = 7'd10;
        invert_polarity = 4'b0001;
        #1;
        check("t5_inv_now", 32'(pwm_sig[0]), 32'(!m_raw[0]));
        meas(0, hi, len, w);
        meas(0, hi, len, w);
        check("t5_pin_hi", hi, 118);
        check("t5_pin_len", len, 128);

        sel_inpins = 1'b0;
        reg_dc[6:0] = 7'd96;
        invert_polarity = 4'b1010;
        meas(0, hi, len, w);
        repeat (59) cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_pwm", 32'(pwm_sig), 32'ha);
        check("t6_ps", 32'(period_start), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        meas(0, hi, len, w);
        check("t6_restart_wait", w, 1);
        check("t6_hi", hi, 96);
        check("t6_len", len, 128);

        for (int s = 0; s < 25; s++) begin
            en = ($urandom_range(0, 7) != 0);
            presc = PW'($urandom_range(0, 3));
            center_mode = 1'($urandom_range(0, 1));
            sel_inpins = 1'($urandom_range(0, 1));
            invert_polarity = NCH'($urandom);
            for (int i = 0; i < NCH; i++) begin
                d = $urandom_range(0, 4);
                reg_dc[i*DW +: DW] = (d == 0) ? 7'd0 : (d == 1) ? 7'd127 : (d == 2) ? 7'd1 : 7'($urandom);
                pin_dc[i*DW +: DW] = (d == 3) ? 7'd126 : 7'($urandom);
            end
            for (int k = 0, n = $urandom_range(100, 700); k < n; k++) begin
                if ($urandom_range(0, 99) == 0) reg_dc[$urandom_range(0, NCH-1)*DW +: DW] = 7'($urandom);
                if ($urandom_range(0, 149) == 0) center_mode = ~center_mode;
                if ($urandom_range(0, 149) == 0) invert_polarity = NCH'($urandom);
                if ($urandom_range(0, 299) == 0) en = ~en;
                if ($urandom_range(0, 399) == 0) begin
                    rst_n = 1'b0;
                    model_reset();
                    #1;
                    check("rnd_rst", 32'(pwm_sig), 32'(invert_polarity));
                    repeat (2) cyc();
                    rst_n = 1'b1;
                end
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
